// File: rtl/fact_pkg.sv
// Shared constants for the factorial job scheduler:
// unit register map, status bits and controller states.
package fact_pkg;

   localparam logic [1:0] A_N    = 2'd0;
   localparam logic [1:0] A_GO   = 2'd1;
   localparam logic [1:0] A_STAT = 2'd2;
   localparam logic [1:0] A_RES  = 2'd3;

   localparam int ST_DONE = 0;
   localparam int ST_ERR  = 1;

   typedef enum logic [2:0] {
      IDLE,
      WR_N,
      WR_GO,
      POLL_A,
      POLL_S,
      RD_A,
      RD_S,
      RESP
   } state_t;

endpackage

// File: rtl/fact_rr_arb.sv
// Round-robin picker: first requester after ptr, wrapping.
// Purely combinational; caller owns the pointer register.
module fact_rr_arb #(
   parameter int NREQ = 4,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] onehot,
   output logic [IW-1:0]   idx
);

   int j;

   // Walk farthest-first so the nearest hit after ptr wins.
   always_comb begin
      onehot = '0;
      idx    = '0;
      j      = 0;
      for (int k = NREQ; k >= 1; k--) begin
         j = (int'(ptr) + k) % NREQ;
         if (req[j]) begin
            onehot    = '0;
            onehot[j] = 1'b1;
            idx       = IW'(j);
         end
      end
   end

endmodule

// File: rtl/fact_sched.sv
// Shares one polled factorial unit among NREQ requesters:
// arbitrates, runs the write/poll/read sequence, returns n!.
module fact_sched
   import fact_pkg::*;
#(
   parameter  int NREQ    = 4,
   parameter  int NWIDTH  = 4,
   parameter  int TIMEOUT = 1023,
   localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int CW      = $clog2(TIMEOUT + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*NWIDTH-1:0] req_n,
   output logic [NREQ-1:0]        grant,
   output logic                   resp_valid,
   output logic [IW-1:0]          resp_id,
   output logic [31:0]            resp_data,
   output logic                   resp_err,
   output logic                   resp_tmo,
   output logic                   fact_we,
   output logic [1:0]             fact_a,
   output logic [NWIDTH-1:0]      fact_wd,
   input  logic [31:0]            fact_rd,
   output logic                   busy
);

   state_t            state_q, state_d;
   logic [IW-1:0]     ptr_q, id_q;
   logic [NREQ-1:0]   oh_q;
   logic [NWIDTH-1:0] n_q;
   logic [CW-1:0]     cnt_q, cnt_inc;
   logic [31:0]       res_q;
   logic              err_q, tmo_q;
   logic [NREQ-1:0]   win_oh;
   logic [IW-1:0]     win_idx;
   logic              done, last_poll;

   fact_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
      .req    (req),
      .ptr    (ptr_q),
      .onehot (win_oh),
      .idx    (win_idx)
   );

   assign done      = fact_rd[ST_DONE];
   assign cnt_inc   = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
   assign last_poll = (cnt_inc == CW'(TIMEOUT));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (|req) state_d = WR_N;
         WR_N:    state_d = WR_GO;
         WR_GO:   state_d = POLL_A;
         POLL_A:  state_d = POLL_S;
         POLL_S:  begin
            if (done)           state_d = RD_A;
            else if (last_poll) state_d = RESP;
            else                state_d = POLL_A;
         end
         RD_A:    state_d = RD_S;
         RD_S:    state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state_q != IDLE);
      grant      = (busy && state_q != RESP) ? oh_q : '0;
      fact_we    = 1'b0;
      fact_a     = 2'd0;
      fact_wd    = '0;
      resp_valid = (state_q == RESP);
      resp_id    = resp_valid ? id_q : '0;
      resp_err   = resp_valid & err_q;
      resp_tmo   = resp_valid & tmo_q;
      resp_data  = (resp_valid && !err_q && !tmo_q) ? res_q : '0;
      unique case (state_q)
         WR_N:   begin
            fact_we = 1'b1;
            fact_a  = A_N;
            fact_wd = n_q;
         end
         WR_GO:  begin
            fact_we = 1'b1;
            fact_a  = A_GO;
            fact_wd = NWIDTH'(1);
         end
         POLL_A, POLL_S: fact_a = A_STAT;
         RD_A, RD_S:     fact_a = A_RES;
         default:        fact_a = 2'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= IW'(NREQ - 1);
         id_q    <= '0;
         oh_q    <= '0;
         n_q     <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (|req) begin
               ptr_q <= win_idx;
               id_q  <= win_idx;
               oh_q  <= win_oh;
               n_q   <= req_n[win_idx*NWIDTH +: NWIDTH];
               cnt_q <= '0;
               res_q <= '0;
               err_q <= 1'b0;
               tmo_q <= 1'b0;
            end
            POLL_S: begin
               if (done) begin
                  err_q <= fact_rd[ST_ERR];
               end else begin
                  cnt_q <= cnt_inc;
                  if (last_poll) tmo_q <= 1'b1;
               end
            end
            RD_S:    res_q <= fact_rd;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/fact_sched.md
FACT_SCHED -- requirements
Module: fact_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one factorial unit.
REQ-002 Parameter NWIDTH, default 4, width of operand n.
REQ-003 Parameter TIMEOUT, default 1023, maximum status polls per job before abort.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req  in  NREQ  per-requester job request, held high until its response.
REQ-007 req_n  in  NREQ*NWIDTH  packed operands, slice i belongs to req[i].
REQ-008 grant  out  NREQ  one-hot owner of the factorial unit, zero when idle.
REQ-009 resp_valid  out  1  one-cycle response strobe.
REQ-010 resp_id  out  clog2(NREQ)  index of the requester being answered.
REQ-011 resp_data  out  32  n! result, zero on error.
REQ-012 resp_err  out  1  overflow flag from the unit (status bit1).
REQ-013 resp_tmo  out  1  poll timeout abort.
REQ-014 fact_we, fact_a[1:0], fact_wd[NWIDTH-1:0]  out  write/address bus to the factorial unit.
REQ-015 fact_rd  in  32  factorial unit read data, valid the cycle after fact_a is presented.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 Unit map: A=0 N, A=1 GO (wd bit0), A=2 status (bit0 done, bit1 err), A=3 result.
REQ-018 States: IDLE, WR_N, WR_GO, POLL_A, POLL_S, RD_A, RD_S, RESP.
REQ-019 IDLE: when any req is high, pick a winner round-robin, latch its index and operand, assert grant, go to WR_N.
REQ-020 Round-robin: search starts at the index after the last winner; on simultaneous requests the first hit in that order wins; the pointer updates only on a grant.
REQ-021 WR_N: fact_we=1, fact_a=0, fact_wd=latched n for one cycle.
REQ-022 WR_GO: fact_we=1, fact_a=1, fact_wd=1 for one cycle.
REQ-023 POLL_A: fact_we=0, fact_a=2; POLL_S samples fact_rd.
REQ-024 POLL_S transitions:
- done=1 goes to RD_A.
- done=0 increments the poll counter and returns to POLL_A.
- When the counter reaches TIMEOUT, go to RESP with resp_tmo=1.
REQ-025 RD_A presents fact_a=3; RD_S captures fact_rd and the err bit from the last status read; then go to RESP.
REQ-026 RESP drives resp_valid=1 for exactly one cycle with resp_id and result, clears grant, and returns to IDLE.
REQ-027 If err=1 or a timeout occurred, resp_data shall be 0.
REQ-028 Best-case latency from a req rising in IDLE to resp_valid is 7 cycles: grant, WR_N, WR_GO, POLL_A, POLL_S, RD_A, RD_S, then RESP.
REQ-029 A requester deasserting req mid-job does not abort the job; the response is still issued.
REQ-030 A requester whose req is still high in the cycle after its RESP is treated as a new request.
REQ-031 req_n changes after grant are ignored.
REQ-032 fact_we shall be 0 in every state except WR_N and WR_GO.

Reset
REQ-033 On rst, immediately in any state, including mid-job:
- state becomes IDLE.
- grant, resp_valid, resp_id, resp_data, resp_err, resp_tmo, fact_we, fact_a, fact_wd, and busy become 0.
- The round-robin pointer becomes NREQ-1, so requester 0 has first priority.
- The poll counter clears.
REQ-034 No response is generated for a job interrupted by reset.

Structure
REQ-035 Package fact_pkg shall hold the address constants (A_N, A_GO, A_STAT, A_RES), the status bit positions, and the state enumeration.
REQ-036 The round-robin picker shall be sub-module fact_rr_arb (req, pointer in; one-hot and index out, combinational).
REQ-037 The poll counter shall be clog2(TIMEOUT+1) bits wide and saturate.

Verification
REQ-038 Single request: req[0]=1, n=5 -> fact_we pulses at A=0 wd=5 then A=1 wd=1; resp_valid with id=0 and data=0x00000078, err=0.
REQ-039 Edge operand: n=0 -> data=0x00000001; n=12 -> data=0x1C8CFC00; n=13 with the unit flagging err -> err=1, data=0.
REQ-040 Simultaneous requests: req[1] and req[2] rise together after reset -> id 1 served first, then id 2; grants never overlap.
REQ-041 Fairness: all four req held high continuously -> response ids 0,1,2,3,0,1 in order.
REQ-042 Stuck unit: status done held at 0 -> resp_tmo=1, data=0 after TIMEOUT polls, and the next requester is then served.
REQ-043 Reset mid-job: rst pulsed during POLL_S -> all outputs 0 immediately, no resp_valid; a fresh req[0] with n=3 then returns 0x6.
